// File: rtl/mc_pkg.sv
// Shared types and constants for the multicycle MIPS control unit.
// Optional bne support is enabled by defining MC_BNE_EN.
package mc_pkg;

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXECUTE = 4'd6,
        ALUWB   = 4'd7,
        BRANCH  = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JUMP    = 4'd11
    } state_t;

    // ADD is the zero encoding so states that do not use the ALU default to add.
    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    localparam logic [2:0] ALUC_AND = 3'b000;
    localparam logic [2:0] ALUC_OR  = 3'b001;
    localparam logic [2:0] ALUC_ADD = 3'b010;
    localparam logic [2:0] ALUC_SUB = 3'b110;
    localparam logic [2:0] ALUC_SLT = 3'b111;

endpackage

// File: rtl/mc_aludec.sv
// Combinational ALU decoder: aluop and funct field to ALU control.
// Unknown funct codes fall back to add without flagging anything.
module mc_aludec
    import mc_pkg::*;
(
    input  aluop_t      aluop,
    input  logic [5:0]  funct,
    output logic [2:0]  alucontrol
);

    always_comb begin
        alucontrol = ALUC_ADD;
        case (aluop)
            ALUOP_SUB: alucontrol = ALUC_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FUNCT_ADD: alucontrol = ALUC_ADD;
                    FUNCT_SUB: alucontrol = ALUC_SUB;
                    FUNCT_AND: alucontrol = ALUC_AND;
                    FUNCT_OR:  alucontrol = ALUC_OR;
                    FUNCT_SLT: alucontrol = ALUC_SLT;
                    default:   alucontrol = ALUC_ADD;
                endcase
            end
            default: alucontrol = ALUC_ADD;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Moore control FSM for the multicycle MIPS datapath; dbg_state exposes the state.
// Defining MC_BNE_EN decodes op 000101 (bne) as a branch taken on zero=0.
module mc_controller
    import mc_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic [5:0]  op,
    input  logic [5:0]  funct,
    input  logic        zero,
    output logic        pcen,
    output logic        irwrite,
    output logic        regwrite,
    output logic        memwrite,
    output logic        alusrca,
    output logic        iord,
    output logic        memtoreg,
    output logic        regdst,
    output logic [1:0]  alusrcb,
    output logic [1:0]  pcsrc,
    output logic [2:0]  alucontrol,
    output logic        illegal,
    output state_t      dbg_state
);

    state_t state, state_next;
    aluop_t aluop;
    logic   pcwrite;
    logic   branch;
    logic   bne_sel;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= FETCH;
        else          state <= state_next;
    end

    always_comb begin
        state_next = FETCH;
        illegal    = 1'b0;
        irwrite    = 1'b0;
        pcwrite    = 1'b0;
        branch     = 1'b0;
        regwrite   = 1'b0;
        memwrite   = 1'b0;
        alusrca    = 1'b0;
        iord       = 1'b0;
        memtoreg   = 1'b0;
        regdst     = 1'b0;
        alusrcb    = 2'b00;
        pcsrc      = 2'b00;
        aluop      = ALUOP_ADD;
        case (state)
            FETCH: begin
                state_next = DECODE;
                irwrite    = 1'b1;
                pcwrite    = 1'b1;
                alusrcb    = 2'b01;
            end
            DECODE: begin
                alusrcb = 2'b11;
                case (op)
                    OP_LW, OP_SW: state_next = MEMADR;
                    OP_RTYPE:     state_next = EXECUTE;
                    OP_BEQ:       state_next = BRANCH;
`ifdef MC_BNE_EN
                    OP_BNE:       state_next = BRANCH;
`endif
                    OP_ADDI:      state_next = ADDIEX;
                    OP_J:         state_next = JUMP;
                    default: begin
                        state_next = FETCH;
                        illegal    = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                state_next = (op == OP_LW) ? MEMRD : MEMWR;
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
            end
            ADDIEX: begin
                state_next = ADDIWB;
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
            end
            MEMRD: begin
                state_next = MEMWB;
                iord       = 1'b1;
            end
            MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
            end
            MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
            end
            EXECUTE: begin
                state_next = ALUWB;
                alusrca    = 1'b1;
                aluop      = ALUOP_FUNCT;
            end
            ALUWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
            end
            ADDIWB: regwrite = 1'b1;
            BRANCH: begin
                alusrca = 1'b1;
                aluop   = ALUOP_SUB;
                pcsrc   = 2'b01;
                branch  = 1'b1;
            end
            JUMP: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
            end
            default: state_next = FETCH;
        endcase
    end

`ifdef MC_BNE_EN
    assign bne_sel = (op == OP_BNE);
`else
    assign bne_sel = 1'b0;
`endif

    // zero is the live ALU flag, so the branch decision resolves in the BRANCH cycle itself.
    assign pcen      = pcwrite | (branch & (zero ^ bne_sel));
    assign dbg_state = state;

    mc_aludec u_aludec (
        .aluop      (aluop),
        .funct      (funct),
        .alucontrol (alucontrol)
    );

endmodule
